// File: rtl/fifo_tx_pkg.sv
// Shared types and header-word layout for the FIFO write-side scheduler.
package fifo_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } tx_state_t;

  localparam int HDR_ID_LSB  = 0;
  localparam int HDR_SEQ_LSB = 8;
  localparam int ID8_W       = 8;
  localparam int SEQ_W       = 8;
  localparam int GRANT_W     = 4;

  // The header flag sits just above the payload, so it tracks the data width.
  function automatic int hdr_flag_pos(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/fifo_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last, cyclically.
module rr_pick
  import fifo_tx_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [GRANT_W-1:0] i_last,
  output logic [GRANT_W-1:0] o_grant,
  output logic               o_any
);

  // Distance 1..NUM_SRC from i_last; i_last itself ranks last.
  always_comb begin
    int w_dist;
    int w_best;
    w_dist  = 0;
    w_best  = NUM_SRC + 1;
    o_grant = i_last;
    o_any   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = i - int'(i_last);
      if (w_dist <= 0) w_dist = w_dist + NUM_SRC;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = GRANT_W'(i);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Round-robin write scheduler: header word then up to MAX_BURST data words per grant.
module fifo_tx_arbiter
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_SRC      = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 15
) (
  input  logic                          w_clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH:0]           fifo_w_in,
  input  logic                          fifo_w_full,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy
);

  localparam int FLAG_POS = hdr_flag_pos(DATA_WIDTH);

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [GRANT_W-1:0]   w_pick;
  logic                 w_any;
  logic                 r_busy;
  logic [SEQ_W-1:0]     r_seq [NUM_SRC];
  logic [7:0]           r_wcnt;
  logic [7:0]           r_stall;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [SEQ_W-1:0]     w_sel_seq;
  logic [DATA_WIDTH:0]  w_hdr;
  logic                 w_accept;
  logic                 w_hdr_wr;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .i_req   (src_valid),
    .i_last  (r_last_grant),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  // Granted-source view, selected without a variable-width index.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_seq   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == GRANT_W'(i)) begin
        w_sel_valid = src_valid[i];
        w_sel_last  = src_last[i];
        w_sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_seq   = r_seq[i];
      end
    end
  end

  always_comb begin
    w_hdr                           = '0;
    w_hdr[FLAG_POS]                 = 1'b1;
    w_hdr[HDR_SEQ_LSB +: SEQ_W]     = w_sel_seq;
    w_hdr[HDR_ID_LSB +: ID8_W]      = ID8_W'(r_grant);
  end

  always_comb begin
    w_state_nxt = r_state;
    src_ready   = '0;
    fifo_w_en   = 1'b0;
    fifo_w_in   = '0;
    w_accept    = 1'b0;
    w_hdr_wr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        fifo_w_en = ~fifo_w_full;
        fifo_w_in = w_hdr;
        w_hdr_wr  = ~fifo_w_full;
        if (!fifo_w_full) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (r_grant == GRANT_W'(i)) src_ready[i] = ~fifo_w_full;
        end
        fifo_w_en = w_sel_valid & ~fifo_w_full;
        fifo_w_in = {1'b0, w_sel_data};
        w_accept  = w_sel_valid & ~fifo_w_full;
        if (w_accept && (w_sel_last || (r_wcnt + 8'd1 == 8'(MAX_BURST))))
          w_state_nxt = ST_IDLE;
        else if (!w_sel_valid && (r_stall + 8'd1 == 8'(IDLE_TIMEOUT)))
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GRANT_W'(NUM_SRC - 1);
      r_busy       <= 1'b0;
      r_wcnt       <= '0;
      r_stall      <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_seq[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_IDLE && w_any) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end
      if (w_hdr_wr) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (r_grant == GRANT_W'(i)) r_seq[i] <= r_seq[i] + 8'd1;
        end
        r_wcnt  <= '0;
        r_stall <= '0;
      end else if (w_accept) begin
        r_wcnt  <= r_wcnt + 8'd1;
        r_stall <= '0;
      end else if (r_state == ST_DATA && !w_sel_valid) begin
        r_stall <= r_stall + 8'd1;
      end
    end
  end

  assign grant_id = r_grant;
  assign busy     = r_busy;

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Scoreboard bench for fifo_tx_arbiter: expected FIFO words queued at stimulus time.
module tb_fifo_tx_arbiter;

  localparam int DW = 16;
  localparam int NS = 4;

  logic             w_clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_last;
  logic [NS-1:0]    src_ready;
  logic             fifo_w_en;
  logic [DW:0]      fifo_w_in;
  logic             fifo_w_full;
  logic [3:0]       grant_id;
  logic             busy;

  fifo_tx_arbiter #(
    .DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BURST(8), .IDLE_TIMEOUT(15)
  ) dut (
    .w_clk       (w_clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .fifo_w_en   (fifo_w_en),
    .fifo_w_in   (fifo_w_in),
    .fifo_w_full (fifo_w_full),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 w_clk = ~w_clk;

  int          total = 0;
  int          bad   = 0;
  int          ncyc  = 0;
  logic        tb_rst;
  logic        tb_full;
  int          rem  [NS];
  int          plen [NS];
  int          pos  [NS];
  int          cnt  [NS];
  int          base [NS];
  int          order [5];
  logic [DW:0] expq [$];
  int          last_hdr_cyc = 0;
  int          last_dat_cyc = 0;
  int          hdr_gap = 0;
  int          c0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, ncyc);
    end
  endtask

  function automatic logic [DW:0] hdr_w(input int id, input int seq);
    logic [DW:0] w;
    w        = '0;
    w[DW]    = 1'b1;
    w[15:8]  = 8'(seq);
    w[7:0]   = 8'(id);
    return w;
  endfunction

  function automatic logic [DW:0] dat_w(input int id, input int k);
    return {1'b0, 4'(id), 12'(k)};
  endfunction

  task automatic load_src(input int i, input int n, input int pl);
    rem[i]  = n;
    plen[i] = pl;
    pos[i]  = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_valid[i]            = (rem[i] > 0);
      src_data[i*DW +: DW]    = {4'(i), 12'(cnt[i])};
      src_last[i]             = (plen[i] != 0) && (pos[i] == plen[i] - 1);
    end
    rst         = tb_rst;
    fifo_w_full = tb_full;
  endtask

  // One clock: drive at the falling edge, sample just after, commit handshakes.
  task automatic cyc();
    logic [DW:0] e;
    @(negedge w_clk);
    drive();
    #1;
    ncyc++;
    if (fifo_w_en === 1'b1) begin
      if (fifo_w_full) chk("en_while_full", 32'(fifo_w_full), 32'd0);
      if (expq.size() == 0) begin
        chk("extra_wr", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        chk("word", 32'(fifo_w_in), 32'(e));
        if (e[DW]) chk("gid", 32'(grant_id), 32'(e[3:0]));
      end
      if (fifo_w_in[DW]) begin
        hdr_gap      = ncyc - last_dat_cyc;
        last_hdr_cyc = ncyc;
      end else begin
        last_dat_cyc = ncyc;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        cnt[i]++;
        rem[i]--;
        pos[i] = src_last[i] ? 0 : pos[i] + 1;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) load_src(i, 0, 0);
    tb_rst = 1'b1;
    repeat (2) cyc();
    tb_rst = 1'b0;
  endtask

  initial begin
    tb_rst  = 1'b1;
    tb_full = 1'b0;
    for (int i = 0; i < NS; i++) begin
      load_src(i, 0, 0);
      cnt[i] = 0;
    end
    drive();

    // Reset state
    do_reset();
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_en", 32'(fifo_w_en), 32'd0);
    chk("rst_rdy", 32'(src_ready), 32'd0);

    // Single source, 3-word packet, exact cycle placement
    load_src(0, 3, 3);
    expq.push_back(hdr_w(0, 0));
    for (int k = 0; k < 3; k++) expq.push_back(dat_w(0, cnt[0] + k));
    cyc();
    c0 = ncyc;
    chk("t1_busy_c0", 32'(busy), 32'd0);
    cyc();
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_en_c1", 32'(fifo_w_en), 32'd1);
    repeat (3) cyc();
    cyc();
    chk("t1_busy_c5", 32'(busy), 32'd0);
    chk("t1_hdr_cyc", 32'(last_hdr_cyc - c0), 32'd1);
    chk("t1_last_dat_cyc", 32'(last_dat_cyc - c0), 32'd4);
    drain("t1_drain", 20);

    // All sources continuously valid, MAX_BURST bursts, rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NS; i++) begin
      load_src(i, (i == 0) ? 16 : 8, 0);
      base[i] = cnt[i];
    end
    order = '{0, 1, 2, 3, 0};
    for (int b = 0; b < 5; b++) begin
      expq.push_back(hdr_w(order[b], (b == 4) ? 1 : 0));
      for (int k = 0; k < 8; k++) expq.push_back(dat_w(order[b], base[order[b]] + k));
      base[order[b]] += 8;
    end
    drain("t2_drain", 200);

    // FIFO full for 5 cycles mid-burst
    load_src(1, 6, 6);
    expq.push_back(hdr_w(1, 1));
    for (int k = 0; k < 6; k++) expq.push_back(dat_w(1, cnt[1] + k));
    repeat (4) cyc();
    tb_full = 1'b1;
    repeat (5) begin
      cyc();
      chk("full_en", 32'(fifo_w_en), 32'd0);
      chk("full_rdy", 32'(src_ready), 32'd0);
    end
    tb_full = 1'b0;
    drain("t3_drain", 40);

    // Granted source goes quiet after 2 words: timeout, then next source
    load_src(2, 2, 0);
    load_src(3, 1, 1);
    expq.push_back(hdr_w(2, 1));
    expq.push_back(dat_w(2, cnt[2]));
    expq.push_back(dat_w(2, cnt[2] + 1));
    expq.push_back(hdr_w(3, 1));
    expq.push_back(dat_w(3, cnt[3]));
    drain("t4_drain", 60);
    chk("t4_timeout_gap", 32'(hdr_gap), 32'd17);

    // Sequence number wraps on the 257th header
    do_reset();
    load_src(2, 257, 1);
    for (int k = 0; k < 257; k++) begin
      expq.push_back(hdr_w(2, k & 255));
      expq.push_back(dat_w(2, cnt[2] + k));
    end
    drain("t5_drain", 1200);

    // Reset asserted mid-DATA
    do_reset();
    load_src(3, 10, 0);
    expq.push_back(hdr_w(3, 0));
    expq.push_back(dat_w(3, cnt[3]));
    expq.push_back(dat_w(3, cnt[3] + 1));
    repeat (3) cyc();
    tb_rst = 1'b1;
    cyc();
    tb_rst = 1'b0;
    load_src(0, 1, 1);
    expq.push_back(hdr_w(0, 0));
    expq.push_back(dat_w(0, cnt[0]));
    expq.push_back(hdr_w(3, 0));
    for (int k = 0; k < 8; k++) expq.push_back(dat_w(3, cnt[3] + k));
    cyc();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_gid", 32'(grant_id), 32'd0);
    chk("t6_rdy", 32'(src_ready), 32'd0);
    chk("t6_en", 32'(fifo_w_en), 32'd0);
    drain("t6_drain", 60);

    // last on the MAX_BURST-th word ends the burst exactly once
    do_reset();
    load_src(1, 8, 8);
    load_src(2, 1, 1);
    expq.push_back(hdr_w(1, 0));
    for (int k = 0; k < 8; k++) expq.push_back(dat_w(1, cnt[1] + k));
    expq.push_back(hdr_w(2, 0));
    expq.push_back(dat_w(2, cnt[2]));
    drain("t7_drain", 40);
    chk("t7_gap", 32'(hdr_gap), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
